// File: rtl/emu_trace_checker_pkg.sv
// emu_trace_checker_pkg: checker state encoding and record layout helper
package emu_trace_checker_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
   // one channel slot in a record is {wen, waddr, wdata}, wdata in the low bits
   function automatic int ch_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction
endpackage

// File: rtl/emu_trace_fifo.sv
// emu_trace_fifo: synchronous FIFO with wrap-bit pointers and occupancy output
module emu_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
      end
   always_ff @(posedge clk)
      if (push && !clear) mem[wptr[AW-1:0]] <= din;
   assign dout  = mem[rptr[AW-1:0]];
   assign empty = wptr == rptr;
   assign full  = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
   assign level = wptr - rptr;
endmodule

// File: rtl/emu_trace_checker.sv
// emu_trace_checker: lock-step DUT/reference writeback trace comparator
module emu_trace_checker
   import emu_trace_checker_pkg::*;
#(
   parameter int NUM_CH    = 1,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int CNT_W     = 32,
   parameter int SKIP_IDLE = 1
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic                                  enable,
   input  logic                                  clear,
   input  logic                                  dut_valid,
   output logic                                  dut_ready,
   input  logic [NUM_CH-1:0]                     dut_wen,
   input  logic [NUM_CH*ADDR_W-1:0]              dut_waddr,
   input  logic [NUM_CH*DATA_W-1:0]              dut_wdata,
   input  logic                                  ref_valid,
   output logic                                  ref_ready,
   input  logic [NUM_CH-1:0]                     ref_wen,
   input  logic [NUM_CH*ADDR_W-1:0]              ref_waddr,
   input  logic [NUM_CH*DATA_W-1:0]              ref_wdata,
   output logic                                  running,
   output logic                                  mismatch,
   output logic [$clog2(NUM_CH):0]               mismatch_ch,
   output logic [NUM_CH*(1+ADDR_W+DATA_W)-1:0]   cap_dut,
   output logic [NUM_CH*(1+ADDR_W+DATA_W)-1:0]   cap_ref,
   output logic [CNT_W-1:0]                      match_count,
   output logic [$clog2(DEPTH):0]                dut_level,
   output logic [$clog2(DEPTH):0]                ref_level
);
   localparam int CW    = ch_w(ADDR_W, DATA_W);
   localparam int REC_W = NUM_CH * CW;
   localparam int CHW   = $clog2(NUM_CH) + 1;
   state_t state, nxt;
   logic [REC_W-1:0] dut_rec, ref_rec, dut_head, ref_head;
   logic [NUM_CH-1:0] diff;
   logic [CHW-1:0] low;
   logic dut_full, ref_full, dut_empty, ref_empty, dut_push, ref_push, do_cmp;
   genvar c;
   for (c = 0; c < NUM_CH; c++) begin : g_ch
      assign dut_rec[c*CW +: CW] = {dut_wen[c], dut_waddr[c*ADDR_W +: ADDR_W], dut_wdata[c*DATA_W +: DATA_W]};
      assign ref_rec[c*CW +: CW] = {ref_wen[c], ref_waddr[c*ADDR_W +: ADDR_W], ref_wdata[c*DATA_W +: DATA_W]};
      // addr/data only matter when the channel actually wrote
      assign diff[c] = dut_head[c*CW+CW-1] != ref_head[c*CW+CW-1] ||
                       (dut_head[c*CW+CW-1] && dut_head[c*CW +: CW-1] != ref_head[c*CW +: CW-1]);
   end
   assign dut_ready = !dut_full;
   assign ref_ready = !ref_full;
   assign dut_push  = dut_valid && dut_ready && !clear && (SKIP_IDLE == 0 || |dut_wen);
   assign ref_push  = ref_valid && ref_ready && !clear && (SKIP_IDLE == 0 || |ref_wen);
   assign do_cmp    = state == RUN && enable && !clear && !dut_empty && !ref_empty;
   emu_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_dut_fifo (
      .clk(clk), .resetn(resetn), .clear(clear), .push(dut_push), .pop(do_cmp),
      .din(dut_rec), .dout(dut_head), .full(dut_full), .empty(dut_empty), .level(dut_level));
   emu_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_ref_fifo (
      .clk(clk), .resetn(resetn), .clear(clear), .push(ref_push), .pop(do_cmp),
      .din(ref_rec), .dout(ref_head), .full(ref_full), .empty(ref_empty), .level(ref_level));
   always_comb begin
      low = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (diff[i]) low = CHW'(i);
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = clear ? IDLE :
            state == IDLE ? (enable ? RUN : IDLE) :
            state == RUN  ? (!enable ? IDLE : (do_cmp && |diff) ? HALT : RUN) : HALT;
   end
   always_comb begin
      running  = state == RUN;
      mismatch = state == HALT;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn || clear) begin
         match_count <= '0;
         mismatch_ch <= '0;
         cap_dut     <= '0;
         cap_ref     <= '0;
      end else if (do_cmp) begin
         if (|diff) begin
            cap_dut     <= dut_head;
            cap_ref     <= ref_head;
            mismatch_ch <= low;
         end else if (!(&match_count)) match_count <= match_count + 1'b1;
      end
endmodule
